// File: rtl/coor_dispatch.sv
// Pixel dispatcher for a pool of Mandelbrot engines: walks the frame, hands each idle
// engine the next {px, py, cx, cy} word, and applies zoom/pan keys between frames.
module coor_dispatch #(
    parameter int                 NUM_ENG = 4,
    parameter int                 ADDR_W  = 3,
    parameter int                 COORD_W = 32,
    parameter int                 H_RES   = 640,
    parameter int                 V_RES   = 480,
    parameter logic [COORD_W-1:0] X0      = '0,
    parameter logic [COORD_W-1:0] Y0      = '0,
    parameter logic [COORD_W-1:0] STEP0   = COORD_W'(256),
    parameter int                 PAN_SH  = 4,
    parameter int                 RR      = 1,
    localparam int                PX_W    = $clog2(H_RES),
    localparam int                PY_W    = $clog2(V_RES),
    localparam int                WORD_W  = PX_W + PY_W + 2 * COORD_W
) (
    input  logic               cclk,
    input  logic               creset,
    input  logic [3:0]         ckey,
    input  logic [NUM_ENG-1:0] cdones,
    output logic               clatch_en,
    output logic [ADDR_W-1:0]  cengine_addr,
    output logic [WORD_W-1:0]  cword2engines,
    output logic               cframe_done,
    output logic [1:0]         cstate
);
    typedef enum logic [1:0] {INIT, SCAN, FLUSH, UPDATE} state_t;

    localparam logic [ADDR_W:0]    NUM_ENG_W = (ADDR_W+1)'(NUM_ENG);
    localparam logic [ADDR_W:0]    ONE_W     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  LAST_ENG  = ADDR_W'(NUM_ENG - 1);
    localparam logic [PX_W-1:0]    PX_LAST   = PX_W'(H_RES - 1);
    localparam logic [PY_W-1:0]    PY_LAST   = PY_W'(V_RES - 1);
    localparam logic [COORD_W-1:0] STEP_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] STEP_MAX  = STEP_ONE << (COORD_W - 2);

    state_t               state_q, state_d;
    logic [PX_W-1:0]      px_q, px_d;
    logic [PY_W-1:0]      py_q, py_d;
    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d, step_q, step_d;
    logic [3:0]           pend_q, pend_d, key_prev_q;
    logic [NUM_ENG-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]    last_q, last_d, addr_q, addr_d;
    logic                 latch_q, latch_d, done_q, done_d;
    logic [WORD_W-1:0]    word_q, word_d;

    logic [NUM_ENG-1:0]   elig, elig_rot;
    logic [ADDR_W:0]      start_w, sum_w;
    logic                 grant_vld;
    logic [ADDR_W-1:0]    grant_idx;
    logic [3:0]           key_edge;
    logic [COORD_W-1:0]   pan_dist, ox_upd, oy_upd, step_upd;

    // Rotate eligibility so bit 0 is the search start, then take the first set bit.
    always_comb begin
        elig    = cdones & ~mask_q;
        start_w = '0;
        if (RR != 0 && last_q != LAST_ENG) start_w = {1'b0, last_q} + ONE_W;
        elig_rot  = NUM_ENG'({elig, elig} >> start_w);
        grant_vld = 1'b0;
        sum_w     = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!grant_vld && elig_rot[k]) begin
                grant_vld = 1'b1;
                sum_w     = start_w + (ADDR_W+1)'(k);
            end
        end
        if (sum_w >= NUM_ENG_W) sum_w = sum_w - NUM_ENG_W;
        grant_idx = sum_w[ADDR_W-1:0];
    end

    // View for the next frame; pan distance uses the step before this update's zoom.
    always_comb begin
        key_edge = ckey & ~key_prev_q;
        pan_dist = step_q << PAN_SH;
        ox_upd   = pend_q[2] ? ox_q + pan_dist : ox_q;
        oy_upd   = pend_q[3] ? oy_q + pan_dist : oy_q;
        step_upd = step_q;
        if (pend_q[0] && !pend_q[1]) begin
            step_upd = (step_q > STEP_ONE) ? step_q >> 1 : STEP_ONE;
        end else if (pend_q[1] && !pend_q[0]) begin
            step_upd = (step_q >= (STEP_MAX >> 1)) ? STEP_MAX : step_q << 1;
        end
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        step_d  = step_q;
        pend_d  = pend_q | key_edge;
        mask_d  = '0;
        last_d  = last_q;
        latch_d = 1'b0;
        addr_d  = addr_q;
        word_d  = word_q;
        done_d  = 1'b0;
        unique case (state_q)
            INIT: begin
                px_d    = '0;
                py_d    = '0;
                cx_d    = ox_q;
                cy_d    = oy_q;
                state_d = SCAN;
            end
            SCAN: begin
                if (grant_vld) begin
                    latch_d = 1'b1;
                    addr_d  = grant_idx;
                    word_d  = {px_q, py_q, cx_q, cy_q};
                    mask_d  = NUM_ENG'(1) << grant_idx;
                    last_d  = grant_idx;
                    if (px_q == PX_LAST) begin
                        px_d = '0;
                        cx_d = ox_q;
                        py_d = py_q + PY_W'(1);
                        cy_d = cy_q - step_q;
                        if (py_q == PY_LAST) state_d = FLUSH;
                    end else begin
                        px_d = px_q + PX_W'(1);
                        cx_d = cx_q + step_q;
                    end
                end
            end
            FLUSH: begin
                if (&cdones) begin
                    done_d  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                ox_d    = ox_upd;
                oy_d    = oy_upd;
                step_d  = step_upd;
                pend_d  = key_edge;
                px_d    = '0;
                py_d    = '0;
                cx_d    = ox_upd;
                cy_d    = oy_upd;
                state_d = SCAN;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (creset) begin
            state_q    <= INIT;
            px_q       <= '0;
            py_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            ox_q       <= X0;
            oy_q       <= Y0;
            step_q     <= STEP0;
            pend_q     <= '0;
            key_prev_q <= '0;
            mask_q     <= '0;
            last_q     <= LAST_ENG;
            latch_q    <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            step_q     <= step_d;
            pend_q     <= pend_d;
            key_prev_q <= ckey;
            mask_q     <= mask_d;
            last_q     <= last_d;
            latch_q    <= latch_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            done_q     <= done_d;
        end
    end

    assign clatch_en     = latch_q;
    assign cengine_addr  = addr_q;
    assign cword2engines = word_q;
    assign cframe_done   = done_q;
    assign cstate        = state_q;
endmodule

// File: tb/tb_coor_dispatch.sv
// Bench for coor_dispatch on a 4x2 frame with four engines; a pixel-index reference
// model predicts every registered output, directed tasks add fixed expected words.
module tb_coor_dispatch;
  localparam int NUM_ENG = 4;
  localparam int H_RES = 4;
  localparam int V_RES = 2;
  localparam int NPIX = H_RES * V_RES;
  localparam int PAN_SH = 4;
  localparam int WORD_W = 67;

  logic cclk;
  logic creset;
  logic [3:0] ckey;
  logic [3:0] cdones;
  logic clatch_en;
  logic [2:0] cengine_addr;
  logic [WORD_W-1:0] cword2engines;
  logic cframe_done;
  logic [1:0] cstate;

  coor_dispatch #(
    .NUM_ENG(4), .ADDR_W(3), .COORD_W(32), .H_RES(4), .V_RES(2),
    .X0(32'd0), .Y0(32'd64), .STEP0(32'd16), .PAN_SH(4), .RR(1)
  ) dut (
    .cclk(cclk), .creset(creset), .ckey(ckey), .cdones(cdones),
    .clatch_en(clatch_en), .cengine_addr(cengine_addr),
    .cword2engines(cword2engines), .cframe_done(cframe_done), .cstate(cstate)
  );

  // clock/reset block
  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  // reference model: phase 0 boot, 1 dispatching, 2 draining, 3 view update
  int m_phase, m_n, m_last, m_prev_g;
  logic [31:0] m_ox, m_oy, m_step;
  logic [3:0] m_pend, m_kprev;
  logic e_latch, e_done;
  logic [2:0] e_addr;
  logic [WORD_W-1:0] e_word;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [WORD_W-1:0] w(input int px, input int py, input logic [31:0] cx, input logic [31:0] cy);
    return {2'(px), 1'(py), cx, cy};
  endfunction

  function automatic logic [WORD_W-1:0] pix(input int n);
    logic [31:0] cx, cy;
    cx = m_ox + m_step * 32'(n % H_RES);
    cy = m_oy - m_step * 32'(n / H_RES);
    return w(n % H_RES, n / H_RES, cx, cy);
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] dn, input logic [3:0] key);
    logic [3:0] edges;
    int g, c;
    longint s2;
    if (rst) begin
      m_phase = 0; m_ox = 32'd0; m_oy = 32'd64; m_step = 32'd16;
      m_pend = 4'h0; m_kprev = 4'h0; m_last = NUM_ENG - 1; m_prev_g = -1; m_n = 0;
      e_latch = 1'b0; e_addr = 3'd0; e_word = '0; e_done = 1'b0;
      return;
    end
    edges = key & ~m_kprev;
    m_kprev = key;
    e_latch = 1'b0;
    e_done = 1'b0;
    case (m_phase)
      0: begin
        m_pend = m_pend | edges; m_n = 0; m_prev_g = -1; m_phase = 1;
      end
      1: begin
        m_pend = m_pend | edges;
        g = -1;
        for (int k = 1; k <= NUM_ENG; k++) begin
          c = (m_last + k) % NUM_ENG;
          if (g < 0 && dn[c[1:0]] && c != m_prev_g) g = c;
        end
        m_prev_g = g;
        if (g >= 0) begin
          e_latch = 1'b1; e_addr = 3'(g); e_word = pix(m_n);
          m_last = g; m_n++;
          if (m_n == NPIX) m_phase = 2;
        end
      end
      2: begin
        m_pend = m_pend | edges; m_prev_g = -1;
        if (dn == 4'hF) begin e_done = 1'b1; m_phase = 3; end
      end
      default: begin
        if (m_pend[2]) m_ox = m_ox + (m_step << PAN_SH);
        if (m_pend[3]) m_oy = m_oy + (m_step << PAN_SH);
        if (m_pend[0] && !m_pend[1]) m_step = (m_step > 32'd1) ? m_step / 2 : 32'd1;
        else if (m_pend[1] && !m_pend[0]) begin
          s2 = longint'(m_step) * 2;
          m_step = (s2 > (64'sd1 <<< 30)) ? 32'h4000_0000 : 32'(s2);
        end
        m_pend = edges; m_n = 0; m_prev_g = -1; m_phase = 1;
      end
    endcase
  endtask

  // driver tasks
  task automatic tick(input logic [3:0] dn, input logic [3:0] key);
    cdones = dn;
    ckey = key;
    @(posedge cclk);
    model_edge(creset, dn, key);
    #1;
  endtask

  task automatic do_reset;
    creset = 1'b1;
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);
    creset = 1'b0;
  endtask

  task automatic test_reset;
    creset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(4'hF, 4'h5);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got latch=%0b addr=%0d word=%h done=%0b, want all zero", clatch_en, cengine_addr, cword2engines, cframe_done);
      end
    end
    creset = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [WORD_W-1:0] tw [5];
    logic [2:0] ta [5];
    tw = '{w(0, 0, 0, 64), w(1, 0, 16, 64), w(2, 0, 32, 64), w(3, 0, 48, 64), w(0, 1, 0, 48)};
    ta = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    tick(4'hF, 4'h0);
    n_checks++;
    if (clatch_en !== 1'b0) begin
      n_fail++; $display("FAIL rr_init_cycle: got latch=%0b, want 0", clatch_en);
    end
    for (int i = 0; i < 5; i++) begin
      tick(4'hF, 4'h0);
      n_checks++;
      if (clatch_en !== 1'b1 || cengine_addr !== ta[i] || cword2engines !== tw[i]) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got latch=%0b addr=%0d word=%h, want latch=1 addr=%0d word=%h", i, clatch_en, cengine_addr, cword2engines, ta[i], tw[i]);
      end
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done}) begin
        n_fail++;
        $display("FAIL rr_model %0d: got latch=%0b addr=%0d word=%h, want latch=%0b addr=%0d word=%h", i, clatch_en, cengine_addr, cword2engines, e_latch, e_addr, e_word);
      end
    end
  endtask

  task automatic test_single_engine;
    int grants;
    logic prev;
    do_reset();
    tick(4'h2, 4'h0);
    grants = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(4'h2, 4'h0);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines} !== {e_latch, e_addr, e_word} || (clatch_en && cengine_addr !== 3'd1) || (clatch_en && prev)) begin
        n_fail++;
        $display("FAIL single_engine %0d: got latch=%0b addr=%0d word=%h prev_latch=%0b, want latch=%0b addr=%0d word=%h", i, clatch_en, cengine_addr, cword2engines, prev, e_latch, e_addr, e_word);
      end
      if (clatch_en === 1'b1) grants++;
      prev = clatch_en;
    end
    n_checks++;
    if (grants !== 4) begin
      n_fail++; $display("FAIL single_engine_count: got %0d grants, want 4", grants);
    end
  endtask

  task automatic test_stall;
    do_reset();
    tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick(4'h0, 4'h0);
      n_checks++;
      if (clatch_en !== 1'b0 || cword2engines !== w(1, 0, 16, 64) || cword2engines !== e_word) begin
        n_fail++;
        $display("FAIL stall_frozen %0d: got latch=%0b word=%h, want latch=0 word=%h", i, clatch_en, cword2engines, w(1, 0, 16, 64));
      end
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (clatch_en !== 1'b1 || cengine_addr !== 3'd2 || cword2engines !== w(2, 0, 32, 64)) begin
      n_fail++;
      $display("FAIL stall_resume: got latch=%0b addr=%0d word=%h, want latch=1 addr=2 word=%h", clatch_en, cengine_addr, cword2engines, w(2, 0, 32, 64));
    end
  endtask

  task automatic test_frame_end;
    do_reset();
    tick(4'hF, 4'h0);
    for (int i = 0; i < NPIX; i++) begin
      tick(4'hF, 4'h0);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done}) begin
        n_fail++;
        $display("FAIL frame_pixels %0d: got latch=%0b addr=%0d word=%h done=%0b, want latch=%0b addr=%0d word=%h done=%0b", i, clatch_en, cengine_addr, cword2engines, cframe_done, e_latch, e_addr, e_word, e_done);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'h7, 4'h0);
      n_checks++;
      if (clatch_en !== 1'b0 || cframe_done !== 1'b0) begin
        n_fail++; $display("FAIL flush_wait %0d: got latch=%0b done=%0b, want 0 0", i, clatch_en, cframe_done);
      end
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (cframe_done !== 1'b1 || clatch_en !== 1'b0) begin
      n_fail++; $display("FAIL frame_done_pulse: got done=%0b latch=%0b, want done=1 latch=0", cframe_done, clatch_en);
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (cframe_done !== 1'b0 || clatch_en !== 1'b0) begin
      n_fail++; $display("FAIL frame_done_width: got done=%0b latch=%0b, want 0 0", cframe_done, clatch_en);
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (clatch_en !== 1'b1 || cengine_addr !== 3'd0 || cword2engines !== w(0, 0, 0, 64)) begin
      n_fail++;
      $display("FAIL next_frame_start: got latch=%0b addr=%0d word=%h, want latch=1 addr=0 word=%h", clatch_en, cengine_addr, cword2engines, w(0, 0, 0, 64));
    end
  endtask

  task automatic test_keys;
    do_reset();
    tick(4'hF, 4'h0);
    for (int i = 0; i < NPIX + 2; i++) begin
      tick(4'hF, (i == 3) ? 4'b0101 : 4'h0);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done} || (i == 4 && cword2engines !== w(0, 1, 0, 48))) begin
        n_fail++;
        $display("FAIL keys_frame %0d: got latch=%0b addr=%0d word=%h done=%0b, want latch=%0b addr=%0d word=%h done=%0b", i, clatch_en, cengine_addr, cword2engines, cframe_done, e_latch, e_addr, e_word, e_done);
      end
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (cword2engines !== w(0, 0, 256, 64)) begin
      n_fail++; $display("FAIL keys_origin: got word=%h, want %h", cword2engines, w(0, 0, 256, 64));
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (cengine_addr !== 3'd1 || cword2engines !== w(1, 0, 264, 64)) begin
      n_fail++; $display("FAIL keys_step: got addr=%0d word=%h, want addr=1 word=%h", cengine_addr, cword2engines, w(1, 0, 264, 64));
    end
  endtask

  task automatic test_key_at_update;
    do_reset();
    tick(4'hF, 4'h0);
    for (int i = 0; i < NPIX + 1; i++) tick(4'hF, 4'h0);
    tick(4'hF, 4'b1000);
    tick(4'hF, 4'b1000);
    n_checks++;
    if (cword2engines !== w(0, 0, 0, 64) || cword2engines !== e_word) begin
      n_fail++; $display("FAIL update_key_deferred: got word=%h, want %h", cword2engines, w(0, 0, 0, 64));
    end
    for (int i = 0; i < NPIX + 1; i++) tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    n_checks++;
    if (cword2engines !== w(0, 0, 0, 320) || cword2engines !== e_word) begin
      n_fail++; $display("FAIL update_key_applied: got word=%h, want %h", cword2engines, w(0, 0, 0, 320));
    end
  endtask

  task automatic test_zoom;
    do_reset();
    tick(4'hF, 4'h0);
    for (int f = 0; f < 6; f++) begin
      for (int t = 0; t < NPIX + 2; t++) begin
        tick(4'hF, (t != 0) ? 4'h0 : ((f == 0) ? 4'b0011 : 4'b0001));
        n_checks++;
        if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done} || (f == 1 && t == 1 && cword2engines !== w(1, 0, 16, 64))) begin
          n_fail++;
          $display("FAIL zoom f=%0d t=%0d: got latch=%0b addr=%0d word=%h done=%0b, want latch=%0b addr=%0d word=%h done=%0b", f, t, clatch_en, cengine_addr, cword2engines, cframe_done, e_latch, e_addr, e_word, e_done);
        end
      end
    end
    tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    n_checks++;
    if (cword2engines !== w(1, 0, 1, 64)) begin
      n_fail++; $display("FAIL zoom_floor: got word=%h, want %h", cword2engines, w(1, 0, 1, 64));
    end
  endtask

  task automatic test_zoom_out_limit;
    do_reset();
    tick(4'hF, 4'h0);
    for (int f = 0; f < 30; f++) begin
      for (int t = 0; t < NPIX + 2; t++) begin
        tick(4'hF, (t == 0) ? 4'b0010 : 4'h0);
        n_checks++;
        if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done}) begin
          n_fail++;
          $display("FAIL zoom_out f=%0d t=%0d: got latch=%0b addr=%0d word=%h done=%0b, want latch=%0b addr=%0d word=%h done=%0b", f, t, clatch_en, cengine_addr, cword2engines, cframe_done, e_latch, e_addr, e_word, e_done);
        end
      end
    end
    tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    n_checks++;
    if (cword2engines !== w(1, 0, 32'h4000_0000, 64)) begin
      n_fail++; $display("FAIL zoom_out_sat: got word=%h, want %h", cword2engines, w(1, 0, 32'h4000_0000, 64));
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    tick(4'hF, 4'h0);
    for (int i = 0; i < 3; i++) tick(4'hF, 4'h0);
    creset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(4'hF, 4'h0);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== '0) begin
        n_fail++;
        $display("FAIL midreset_outputs %0d: got latch=%0b addr=%0d word=%h done=%0b, want all zero", i, clatch_en, cengine_addr, cword2engines, cframe_done);
      end
    end
    creset = 1'b0;
    tick(4'hF, 4'h0);
    n_checks++;
    if (clatch_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_init: got latch=%0b, want 0", clatch_en);
    end
    tick(4'hF, 4'h0);
    n_checks++;
    if (clatch_en !== 1'b1 || cengine_addr !== 3'd0 || cword2engines !== w(0, 0, 0, 64)) begin
      n_fail++;
      $display("FAIL midreset_restart: got latch=%0b addr=%0d word=%h, want latch=1 addr=0 word=%h", clatch_en, cengine_addr, cword2engines, w(0, 0, 0, 64));
    end
  endtask

  task automatic test_random;
    logic [3:0] dn, key;
    do_reset();
    key = 4'h0;
    for (int t = 0; t < 1500; t++) begin
      creset = ($urandom_range(0, 199) == 0);
      dn = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) key = key ^ 4'(1 << $urandom_range(0, 3));
      tick(dn, key);
      n_checks++;
      if ({clatch_en, cengine_addr, cword2engines, cframe_done} !== {e_latch, e_addr, e_word, e_done}) begin
        n_fail++;
        $display("FAIL random t=%0d: got latch=%0b addr=%0d word=%h done=%0b, want latch=%0b addr=%0d word=%h done=%0b", t, clatch_en, cengine_addr, cword2engines, cframe_done, e_latch, e_addr, e_word, e_done);
      end
    end
    creset = 1'b0;
  endtask

  initial begin
    creset = 1'b1;
    ckey = 4'h0;
    cdones = 4'h0;
    test_reset();
    test_round_robin();
    test_single_engine();
    test_stall();
    test_frame_end();
    test_keys();
    test_key_at_update();
    test_zoom();
    test_zoom_out_limit();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coor_dispatch.md
COOR_DISPATCH -- requirements
Module: coor_dispatch

Interface
REQ-001 Parameter NUM_ENG, default 4: number of Mandelbrot engines served (1..2**ADDR_W).
REQ-002 Parameter ADDR_W, default 3: engine address width.
REQ-003 Parameter COORD_W, default 32: signed fixed-point width of cx and cy, in two's complement.
REQ-004 Parameter H_RES / V_RES, default 640 / 480: frame size in pixels; PX_W = clog2(H_RES) and PY_W = clog2(V_RES).
REQ-005 Parameters X0, Y0, STEP0, default implementation-chosen constants: reset values of origin x, origin y and step (COORD_W bits each); STEP0 SHALL be greater than 0.
REQ-006 Parameter PAN_SH, default 4: pan distance is step << PAN_SH.
REQ-007 Parameter RR, default 1: 1 selects round-robin engine arbitration; 0 selects fixed priority, where the lowest index wins.
REQ-008 cclk  in  1  sole clock; all logic on the rising edge.
REQ-009 creset  in  1  synchronous, active-high reset.
REQ-010 ckey  in  4  active-high commands: [0] zoom in, [1] zoom out, [2] pan x+, [3] pan y+.
REQ-011 cdones  in  NUM_ENG  bit i high = engine i idle and ready for a new pixel.
REQ-012 clatch_en  out  1  one-cycle strobe: engine cengine_addr latches cword2engines.
REQ-013 cengine_addr  out  ADDR_W  index of the target engine.
REQ-014 cword2engines  out  PX_W+PY_W+2*COORD_W  {px, py, cx, cy}; 83 bits at the defaults.
REQ-015 cframe_done  out  1  one-cycle pulse when a frame has completed.

Function
REQ-016 FSM states SHALL be INIT, SCAN, FLUSH, UPDATE; reset enters INIT, and INIT moves to SCAN after one cycle with px=0, py=0, cx=origin_x, cy=origin_y.
REQ-017 In SCAN, an engine is eligible when its cdones bit is 1 and it is not masked; if any engine is eligible, exactly one SHALL be granted in that cycle.
REQ-018 A grant SHALL register clatch_en=1, cengine_addr=the granted index and cword2engines=the current {px,py,cx,cy}, all valid on the next cycle (1-cycle latency).
REQ-019 The granted engine SHALL be masked for the cycle following its grant, so a slow-falling cdones cannot cause a double dispatch.
REQ-020 Arbitration with RR=1: the search starts at (last granted + 1) mod NUM_ENG; last granted resets to NUM_ENG-1.
REQ-021 No eligible engine: clatch_en=0 and the pixel position does not advance.
REQ-022 Pixel advance on each grant: px+1 and cx+step; at px=H_RES-1, px wraps to 0, cx reloads origin_x, py+1 and cy-step.
REQ-023 Coordinate arithmetic wraps modulo 2**COORD_W without saturation.
REQ-024 The grant of pixel (H_RES-1, V_RES-1) SHALL move the FSM to FLUSH.
REQ-025 In FLUSH, clatch_en=0; the FSM stays until all NUM_ENG cdones bits are 1, then pulses cframe_done for one cycle and enters UPDATE.
REQ-026 ckey rising edges (registered previous value) SHALL set sticky pending bits in any state; pending bits are applied only in UPDATE.
REQ-027 UPDATE, one cycle, applies and clears the pending bits:
  - zoom in: step>>1, floor 1.
  - zoom out: step<<1, saturating at 2**(COORD_W-2).
  - zoom in and zoom out both pending: step unchanged.
  - pan x+: origin_x += step<<PAN_SH.
  - pan y+: origin_y += step<<PAN_SH.
REQ-028 Pan SHALL use the step value held before the same UPDATE's zoom is applied; UPDATE then reloads px, py, cx, cy as in INIT and enters SCAN.
REQ-029 A key edge in the same cycle as UPDATE SHALL be captured as pending for the next frame, not lost.

Reset
REQ-030 While creset=1: clatch_en=0, cengine_addr=0, cword2engines=0, cframe_done=0, pending bits cleared, origin=(X0,Y0), step=STEP0, state INIT.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further strobes, and the next frame restarts at pixel (0,0).

Verification (bench params H_RES=4, V_RES=2, NUM_ENG=4, RR=1, STEP0=16, X0=0, Y0=64)
REQ-032 cdones=4'b1111 steady after reset -> grants to engines 0,1,2,3,0,... on consecutive cycles; words (0,0,0,64),(1,0,16,64),(2,0,32,64),(3,0,48,64),(0,1,0,48).
REQ-033 cdones=4'b0010 held -> engine 1 latched at most every other cycle, with cengine_addr=1 each time.
REQ-034 cdones=0 for 5 cycles mid-frame -> clatch_en=0 and the word frozen; resumes at the next pixel when cdones returns.
REQ-035 All 8 pixels issued, then cdones=4'b0111 for 3 cycles, then 4'b1111 -> cframe_done one cycle after all-ones, and the next frame starts at (0,0).
REQ-036 ckey[0] and ckey[2] pulsed mid-frame -> no effect until UPDATE; next frame origin_x=256 and step=8.
REQ-037 creset pulsed after the 3rd grant -> outputs 0 during reset; the first post-reset word is (0,0,0,64) to engine 0.
